mem_port_arbiter_ctrl: RTL and testbench

- Sequences the single shared memory port between instruction fetch (IF) and the MEM stage.
- Generates the six-bit pipeline stall vector consumed by the PC register and the IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Stall bit k freezes stage register k. A pipeline register inserts a bubble when its own stall bit is set and the next one is clear.
- Discards in-flight fetches made wrong by a taken branch resolved in ID.

---
 rtl/mem_port_arbiter_ctrl_pkg.sv | 19 +
 rtl/mem_port_arbiter_ctrl_stall_encoder.sv | 21 ++
 rtl/mem_port_arbiter_ctrl.sv | 114 +++++++++++
 tb/tb_mem_port_arbiter_ctrl.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_ctrl_pkg.sv
// Shared FSM encodings and stall-vector constants for the memory-port arbiter.
// No logic, so no latency; backpressure is expressed entirely through the stall vectors.
package mem_port_arbiter_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      IF_XFER  = 2'd1,
      MEM_XFER = 2'd2,
      IF_DROP  = 2'd3
   } arb_state_t;

   // Stall bit k freezes stage register k (bit0 PC ... bit5 WB).
   localparam logic [5:0] STALL_NONE = 6'b000000;
   localparam logic [5:0] STALL_IF   = 6'b000011;
   localparam logic [5:0] STALL_ID   = 6'b000111;
   localparam logic [5:0] STALL_EX   = 6'b001111;
   localparam logic [5:0] STALL_MEM  = 6'b011111;

endpackage

// File: rtl/mem_port_arbiter_ctrl_stall_encoder.sv
// Priority encoder from stall sources to the six-bit pipeline stall vector.
// Purely combinational, zero latency; the deepest stalled stage wins.
module mem_port_arbiter_ctrl_stall_encoder
   import mem_port_arbiter_ctrl_pkg::*;
(
   input  logic       mem_stall,
   input  logic       ex_stall,
   input  logic       id_stall,
   input  logic       if_stall,
   output logic [5:0] stall
);

   always_comb begin
      stall = STALL_NONE;
      if (mem_stall)     stall = STALL_MEM;
      else if (ex_stall) stall = STALL_EX;
      else if (id_stall) stall = STALL_ID;
      else if (if_stall) stall = STALL_IF;
   end

endmodule

// File: rtl/mem_port_arbiter_ctrl.sv
// Arbitrates one shared memory port between fetch and MEM (MEM first) and drives pipeline stalls.
// Port request appears the cycle after grant; acks are combinational with port_ack; requesters stall until acked.
module mem_port_arbiter_ctrl
   import mem_port_arbiter_ctrl_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_ack,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              mem_req,
   input  logic              mem_we,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_wdata,
   output logic              mem_ack,
   output logic [DATA_W-1:0] mem_rdata,
   output logic              port_req,
   output logic              port_we,
   output logic [ADDR_W-1:0] port_addr,
   output logic [DATA_W-1:0] port_wdata,
   input  logic              port_ack,
   input  logic [DATA_W-1:0] port_rdata,
   input  logic              stallreq_id,
   input  logic              stallreq_ex,
   input  logic              branch_taken,
   output logic [5:0]        stall
);

   arb_state_t state;

   // A fetch completing in the same cycle as a redirect is stale, so it is not acknowledged.
   assign mem_ack   = (state == MEM_XFER) && port_ack;
   assign if_ack    = (state == IF_XFER) && port_ack && !branch_taken;
   assign mem_rdata = mem_ack ? port_rdata : '0;
   assign if_rdata  = if_ack ? port_rdata : '0;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         port_req   <= 1'b0;
         port_we    <= 1'b0;
         port_addr  <= '0;
         port_wdata <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (mem_req) begin
                  state      <= MEM_XFER;
                  port_req   <= 1'b1;
                  port_we    <= mem_we;
                  port_addr  <= mem_addr;
                  port_wdata <= mem_wdata;
               end else if (if_req && !branch_taken) begin
                  state     <= IF_XFER;
                  port_req  <= 1'b1;
                  port_we   <= 1'b0;
                  port_addr <= if_addr;
               end
            end
            MEM_XFER: begin
               if (port_ack) begin
                  if (if_req) begin
                     state     <= IF_XFER;
                     port_we   <= 1'b0;
                     port_addr <= if_addr;
                  end else begin
                     state    <= IDLE;
                     port_req <= 1'b0;
                  end
               end
            end
            IF_XFER: begin
               if (port_ack) begin
                  if (mem_req) begin
                     state      <= MEM_XFER;
                     port_we    <= mem_we;
                     port_addr  <= mem_addr;
                     port_wdata <= mem_wdata;
                  end else begin
                     state    <= IDLE;
                     port_req <= 1'b0;
                  end
               end else if (branch_taken) begin
                  state <= IF_DROP;
               end
            end
            IF_DROP: begin
               // The memory still owes a response; hold the request and swallow it.
               if (port_ack) begin
                  state    <= IDLE;
                  port_req <= 1'b0;
               end
            end
            default: begin
               state    <= IDLE;
               port_req <= 1'b0;
            end
         endcase
      end
   end

   mem_port_arbiter_ctrl_stall_encoder u_stall_encoder (
      .mem_stall (mem_req && !mem_ack),
      .ex_stall  (stallreq_ex),
      .id_stall  (stallreq_id),
      .if_stall  (if_req && !if_ack && !branch_taken),
      .stall     (stall)
   );

endmodule

// File: tb/tb_mem_port_arbiter_ctrl.sv
// Directed bench with a transaction-level reference model checked every cycle.
module tb_mem_port_arbiter_ctrl;
   import mem_port_arbiter_ctrl_pkg::*;

   localparam int AW = 32;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          if_req, mem_req, mem_we;
   logic [AW-1:0] if_addr, mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          if_ack, mem_ack;
   logic [DW-1:0] if_rdata, mem_rdata;
   logic          port_req, port_we;
   logic [AW-1:0] port_addr;
   logic [DW-1:0] port_wdata;
   logic          port_ack;
   logic [DW-1:0] port_rdata;
   logic          stallreq_id, stallreq_ex, branch_taken;
   logic [5:0]    stall;

   int n_checks = 0;
   int n_errors = 0;
   int ack_lat  = 3;
   logic [DW-1:0] rdata_next = '0;

   always #5 clk = ~clk;

   mem_port_arbiter_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .port_req(port_req), .port_we(port_we), .port_addr(port_addr), .port_wdata(port_wdata),
      .port_ack(port_ack), .port_rdata(port_rdata),
      .stallreq_id(stallreq_id), .stallreq_ex(stallreq_ex), .branch_taken(branch_taken),
      .stall(stall)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Memory responder: answers ack_lat cycles after it first sees an outstanding request.
   initial begin
      int cnt;
      cnt = 0;
      port_ack = 1'b0;
      port_rdata = '0;
      forever begin
         @(posedge clk);
         #1;
         if (!rst) begin
            port_ack = 1'b0;
            cnt = 0;
         end else if (port_ack) begin
            port_ack = 1'b0;
            cnt = 0;
         end else if (port_req) begin
            cnt++;
            if (cnt >= ack_lat) begin
               port_ack = 1'b1;
               port_rdata = rdata_next;
            end
         end
      end
   end

   // Reference model: the current port transaction and the scheduling rules between transactions.
   logic          m_busy = 1'b0, m_mem = 1'b0, m_drop = 1'b0, m_we = 1'b0;
   logic [AW-1:0] m_addr = '0;
   logic [DW-1:0] m_wdata = '0;
   logic          m_done, after_mem, after_if, start_mem, start_if;

   assign m_done    = m_busy && port_ack;
   assign after_mem = m_done && m_mem;
   assign after_if  = m_done && !m_mem && !m_drop;
   assign start_mem = mem_req && (!m_busy || after_if);
   assign start_if  = (!m_busy && !mem_req && if_req && !branch_taken) || (after_mem && if_req);

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_busy <= 1'b0; m_mem <= 1'b0; m_drop <= 1'b0; m_we <= 1'b0;
         m_addr <= '0;   m_wdata <= '0;
      end else if (start_mem) begin
         m_busy <= 1'b1; m_mem <= 1'b1; m_drop <= 1'b0;
         m_we <= mem_we; m_addr <= mem_addr; m_wdata <= mem_wdata;
      end else if (start_if) begin
         m_busy <= 1'b1; m_mem <= 1'b0; m_drop <= 1'b0;
         m_we <= 1'b0;   m_addr <= if_addr;
      end else if (m_done) begin
         m_busy <= 1'b0;
      end else if (m_busy && !m_mem && branch_taken) begin
         m_drop <= 1'b1;
      end
   end

   function automatic logic [5:0] exp_stall(input logic e_if_ack, input logic e_mem_ack);
      if (mem_req && !e_mem_ack)                  return 6'b011111;
      if (stallreq_ex)                            return 6'b001111;
      if (stallreq_id)                            return 6'b000111;
      if (if_req && !e_if_ack && !branch_taken)   return 6'b000011;
      return 6'b000000;
   endfunction

   always @(negedge clk) begin
      logic e_if_ack, e_mem_ack;
      e_if_ack  = m_busy && !m_mem && !m_drop && port_ack && !branch_taken;
      e_mem_ack = m_busy && m_mem && port_ack;
      chk("cmp_port_req", port_req, m_busy);
      chk("cmp_port_we", port_we, m_we);
      chk("cmp_port_addr", port_addr, m_addr);
      chk("cmp_port_wdata", port_wdata, m_wdata);
      chk("cmp_if_ack", if_ack, e_if_ack);
      chk("cmp_mem_ack", mem_ack, e_mem_ack);
      chk("cmp_stall", stall, exp_stall(e_if_ack, e_mem_ack));
      if (e_if_ack)  chk("cmp_if_rdata", if_rdata, port_rdata);
      if (e_mem_ack) chk("cmp_mem_rdata", mem_rdata, port_rdata);
   end

   task automatic wait_if_ack(input string name, input logic [DW-1:0] data);
      logic got;
      got = 1'b0;
      for (int i = 0; i < 30 && !got; i++) begin
         @(negedge clk);
         if (if_ack) got = 1'b1;
         else chk({name, "_stall_pending"}, stall, STALL_IF);
      end
      chk({name, "_ack_seen"}, got, 1'b1);
      if (got) begin
         chk({name, "_rdata"}, if_rdata, data);
         chk({name, "_stall_at_ack"}, stall, STALL_NONE);
      end
      @(posedge clk); #1;
      if_req = 1'b0;
      @(negedge clk);
      chk({name, "_single_pulse"}, if_ack, 1'b0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", n_checks, n_errors);
      $fatal(1);
   end

   initial begin
      int cnt;
      rst = 1'b0;
      if_req = 1'b0; if_addr = '0;
      mem_req = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_wdata = '0;
      stallreq_id = 1'b0; stallreq_ex = 1'b0; branch_taken = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;

      @(negedge clk);
      chk("reset_port_req", port_req, 1'b0);
      chk("reset_stall", stall, STALL_NONE);
      chk("reset_state", 64'(dut.state), 64'(IDLE));
      chk("reset_if_rdata", if_rdata, '0);
      chk("reset_mem_rdata", mem_rdata, '0);

      // Single fetch, memory answers 3 cycles after port_req rises.
      @(posedge clk); #1;
      ack_lat = 3; rdata_next = 32'hDEADBEEF;
      if_req = 1'b1; if_addr = 32'h100;
      wait_if_ack("fetch1", 32'hDEADBEEF);

      // Simultaneous requests: the store goes first, the fetch follows without dropping port_req.
      @(posedge clk); #1;
      ack_lat = 2; rdata_next = 32'h1234_5678;
      if_req = 1'b1; if_addr = 32'h104;
      mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h2000; mem_wdata = 32'h55;
      @(negedge clk);
      chk("prio_stall_grant", stall, STALL_MEM);
      @(negedge clk);
      chk("prio_port_we", port_we, 1'b1);
      chk("prio_port_addr", port_addr, 32'h2000);
      chk("prio_port_wdata", port_wdata, 32'h55);
      cnt = 0;
      while (!mem_ack && cnt < 30) begin
         chk("prio_stall_mem", stall, STALL_MEM);
         @(negedge clk);
         cnt++;
      end
      chk("prio_mem_ack_seen", mem_ack, 1'b1);
      chk("prio_stall_at_ack", stall, STALL_IF);
      @(posedge clk); #1;
      mem_req = 1'b0; mem_we = 1'b0;
      @(negedge clk);
      chk("b2b_port_req", port_req, 1'b1);
      chk("b2b_port_we", port_we, 1'b0);
      chk("b2b_port_addr", port_addr, 32'h104);
      wait_if_ack("fetch2", 32'h1234_5678);

      // Redirect during an in-flight fetch: the stale response is dropped.
      @(posedge clk); #1;
      ack_lat = 4; rdata_next = 32'hBAD0_0200;
      if_req = 1'b1; if_addr = 32'h200;
      @(posedge clk);
      @(posedge clk);
      @(posedge clk); #1;
      branch_taken = 1'b1; if_addr = 32'h300;
      @(negedge clk);
      chk("branch_stall_suppressed", stall, STALL_NONE);
      @(posedge clk); #1;
      branch_taken = 1'b0; rdata_next = 32'hCAFE_0300;
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (if_ack) cnt++;
         if (!port_req) break;
      end
      chk("drop_no_if_ack", cnt, 0);
      chk("drop_idle_port_req", port_req, 1'b0);
      chk("drop_idle_stall", stall, STALL_IF);
      @(negedge clk);
      chk("refetch_port_req", port_req, 1'b1);
      chk("refetch_port_addr", port_addr, 32'h300);
      wait_if_ack("refetch", 32'hCAFE_0300);

      // Later-stage stall requests override the fetch stall.
      @(posedge clk); #1;
      ack_lat = 6; rdata_next = 32'h0000_0400;
      if_req = 1'b1; if_addr = 32'h400; stallreq_ex = 1'b1;
      @(negedge clk);
      chk("ex_stall", stall, STALL_EX);
      @(posedge clk); #1;
      stallreq_ex = 1'b0; stallreq_id = 1'b1;
      @(negedge clk);
      chk("id_stall", stall, STALL_ID);
      @(posedge clk); #1;
      stallreq_id = 1'b0;
      @(negedge clk);
      chk("fetch_stall_after_ex", stall, STALL_IF);
      wait_if_ack("fetch_ex", 32'h0000_0400);

      // Asynchronous reset while a load is outstanding.
      @(posedge clk); #1;
      ack_lat = 8; rdata_next = 32'h3333_3333;
      mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h3000;
      @(posedge clk);
      @(posedge clk); #3;
      chk("pre_reset_port_req", port_req, 1'b1);
      rst = 1'b0;
      #1;
      chk("async_reset_port_req", port_req, 1'b0);
      chk("async_reset_port_addr", port_addr, '0);
      cnt = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (mem_ack) cnt++;
      end
      chk("reset_no_mem_ack", cnt, 0);
      @(posedge clk); #1;
      mem_req = 1'b0;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      chk("post_reset_idle", 64'(dut.state), 64'(IDLE));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
